// File: rtl/gift_pkg.sv
// Shared GIFT-128 key-schedule constants, word layout and writer FSM encoding.
package gift_pkg;

    localparam int GIFT_ROUNDS = 40;
    localparam int RC_W        = 6;
    localparam int KEY_W       = 128;
    localparam int WORD_W      = 136;

    localparam int KEY_LSB = 0;
    localparam int KEY_MSB = 127;
    localparam int RC_LSB  = 128;
    localparam int RC_MSB  = 133;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } wr_state_t;

    // Memory word: two zero pad bits, round constant, then the 128-bit key state.
    function automatic logic [WORD_W-1:0] pack_word(input logic [RC_W-1:0]  rc,
                                                    input logic [KEY_W-1:0] key);
        return {2'b00, rc, key};
    endfunction

endpackage

// File: rtl/gift_key_update.sv
// Combinational GIFT-128 key-state and round-constant step; shared with the decrypt-side schedule.
module gift_key_update
    import gift_pkg::*;
(
    input  logic [KEY_W-1:0] key_i,
    input  logic [RC_W-1:0]  rc_i,
    output logic [KEY_W-1:0] key_o,
    output logic [RC_W-1:0]  rc_o
);

    logic [15:0] k0, k1;

    assign k0 = key_i[15:0];
    assign k1 = key_i[31:16];

    // New k7 = k1 rotated right by 2, new k6 = k0 rotated right by 12, k5..k0 = old k7..k2.
    assign key_o = {k1[1:0], k1[15:2], k0[11:0], k0[15:12], key_i[127:32]};

    assign rc_o = {rc_i[4:0], ~(rc_i[5] ^ rc_i[4])};

endmodule

// File: rtl/gift_round_key_writer.sv
// Streams the 40-word GIFT-128 round-key schedule into the single-port round-key memory.
module gift_round_key_writer
    import gift_pkg::*;
#(
    parameter int ROUNDS    = GIFT_ROUNDS,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              inClk,
    input  logic              inRst,
    input  logic              inStart,
    input  logic [KEY_W-1:0]  inKey,
    output logic              outMemWr,
    output logic [ADDR_W-1:0] outMemAddr,
    output logic [WORD_W-1:0] outMemData,
    output logic              outBusy,
    output logic              outDone,
    output logic              outKeysValid
);

    wr_state_t         state_q;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [RC_W-1:0]   rc_q, rc_d, rc_upd_in;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] data_q;
    logic              wr_q, busy_q, done_q, valid_q;

    // In IDLE the updater sees rc=0 so its output is the round-0 constant.
    assign rc_upd_in = (state_q == ST_IDLE) ? '0 : rc_q;

    gift_key_update u_key_update (
        .key_i (key_q),
        .rc_i  (rc_upd_in),
        .key_o (key_d),
        .rc_o  (rc_d)
    );

    always_ff @(posedge inClk or posedge inRst) begin
        if (inRst) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            rc_q    <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (inStart) begin
                        state_q <= ST_WRITE;
                        key_q   <= inKey;
                        rc_q    <= rc_d;
                        cnt_q   <= '0;
                        addr_q  <= ADDR_W'(BASE_ADDR);
                        data_q  <= pack_word(rc_d, inKey);
                        wr_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (cnt_q == ADDR_W'(ROUNDS - 1)) begin
                        state_q <= ST_DONE;
                        wr_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        valid_q <= 1'b1;
                    end else begin
                        key_q  <= key_d;
                        rc_q   <= rc_d;
                        cnt_q  <= cnt_q + 1'b1;
                        addr_q <= addr_q + 1'b1;
                        data_q <= pack_word(rc_d, key_d);
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign outMemWr     = wr_q;
    assign outMemAddr   = addr_q;
    assign outMemData   = data_q;
    assign outBusy      = busy_q;
    assign outDone      = done_q;
    assign outKeysValid = valid_q;

endmodule

// File: tb/tb_gift_round_key_writer.sv
// Bench for gift_round_key_writer: two instances (base 0 and base 8) against a GIFT-128 schedule model.
module tb_gift_round_key_writer;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_start = 1'b0;
    logic [127:0] in_key = '0;

    logic         wr0, busy0, done0, valid0;
    logic [7:0]   addr0;
    logic [135:0] data0;
    logic         wr8, busy8, done8, valid8;
    logic [7:0]   addr8;
    logic [135:0] data8;

    int n_chk  = 0;
    int n_fail = 0;

    gift_round_key_writer #(.ROUNDS(40), .ADDR_W(8), .BASE_ADDR(0)) u_dut0 (
        .inClk(clk), .inRst(rst), .inStart(in_start), .inKey(in_key),
        .outMemWr(wr0), .outMemAddr(addr0), .outMemData(data0),
        .outBusy(busy0), .outDone(done0), .outKeysValid(valid0)
    );

    gift_round_key_writer #(.ROUNDS(40), .ADDR_W(8), .BASE_ADDR(8)) u_dut8 (
        .inClk(clk), .inRst(rst), .inStart(in_start), .inKey(in_key),
        .outMemWr(wr8), .outMemAddr(addr8), .outMemData(data8),
        .outBusy(busy8), .outDone(done8), .outKeysValid(valid8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Golden round word i for master key: rc stepped i+1 times, key stepped i times.
    function automatic logic [135:0] gold_word(input logic [127:0] key, input int idx);
        logic [15:0]  k[8];
        logic [15:0]  t[8];
        logic [5:0]   c;
        logic [127:0] ks;
        c = 6'h00;
        for (int j = 0; j < 8; j++) k[j] = key[16*j +: 16];
        for (int r = 0; r <= idx; r++) c = {c[4:0], ~(c[5] ^ c[4])};
        for (int r = 0; r < idx; r++) begin
            t[7] = (k[1] >> 2) | (k[1] << 14);
            t[6] = (k[0] >> 12) | (k[0] << 4);
            for (int j = 0; j < 6; j++) t[j] = k[j+2];
            for (int j = 0; j < 8; j++) k[j] = t[j];
        end
        for (int j = 0; j < 8; j++) ks[16*j +: 16] = k[j];
        return {2'b00, c, ks};
    endfunction

    // Behavioural model: phase -1 idle, 0..39 writing word phase, 40 done.
    int           m_phase = -1;
    bit           m_valid = 1'b0;
    logic [7:0]   m_addr0 = '0;
    logic [7:0]   m_addr8 = '0;
    logic [135:0] m_data  = '0;
    logic [135:0] m_words [40];

    task automatic model_reset();
        m_phase = -1;
        m_valid = 1'b0;
        m_addr0 = '0;
        m_addr8 = '0;
        m_data  = '0;
    endtask

    task automatic model_step();
        if (m_phase == -1) begin
            if (in_start) begin
                for (int i = 0; i < 40; i++) m_words[i] = gold_word(in_key, i);
                m_phase = 0;
                m_valid = 1'b0;
            end
        end else if (m_phase < 40) begin
            m_phase++;
            if (m_phase == 40) m_valid = 1'b1;
        end else begin
            m_phase = -1;
        end
        if (m_phase >= 0 && m_phase < 40) begin
            m_data  = m_words[m_phase];
            m_addr0 = 8'(m_phase);
            m_addr8 = 8'(m_phase + 8);
        end
    endtask

    task automatic compare_all();
        logic w;
        w = (m_phase >= 0 && m_phase < 40);
        chk("wr0",    136'(wr0),    136'(w));
        chk("busy0",  136'(busy0),  136'(w));
        chk("done0",  136'(done0),  136'(m_phase == 40));
        chk("valid0", 136'(valid0), 136'(m_valid));
        chk("addr0",  136'(addr0),  136'(m_addr0));
        chk("data0",  data0,        m_data);
        chk("wr8",    136'(wr8),    136'(w));
        chk("busy8",  136'(busy8),  136'(w));
        chk("done8",  136'(done8),  136'(m_phase == 40));
        chk("valid8", 136'(valid8), 136'(m_valid));
        chk("addr8",  136'(addr8),  136'(m_addr8));
        chk("data8",  data8,        m_data);
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
            #1;
            compare_all();
        end
    end

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One start pulse; optional ignored second start and optional async reset at a given cycle.
    task automatic do_run(input logic [127:0] k, input int start2_at, input int rst_at);
        int cyc;
        int strobes;
        bit seen;
        @(negedge clk);
        in_start = 1'b1;
        in_key   = k;
        @(negedge clk);
        in_start = 1'b0;
        in_key   = rand_key();
        cyc = 1;
        strobes = 0;
        seen = 1'b0;
        while (cyc < 60 && !seen) begin
            if (wr0) strobes++;
            if (done0) begin
                seen = 1'b1;
            end else begin
                if (cyc == rst_at) begin
                    #2 rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    in_start = 1'b0;
                    return;
                end
                in_start = (cyc == start2_at);
                in_key   = rand_key();
                @(negedge clk);
                cyc++;
            end
        end
        in_start = 1'b0;
        chk("done_cycle", 136'(cyc), 136'(41));
        chk("strobe_count", 136'(strobes), 136'(40));
    endtask

    initial begin
        // Model pinned against hand-derived values.
        chk("gold_k0_w0",  gold_word(128'h0, 0),  {8'h01, 128'h0});
        chk("gold_k0_w1",  gold_word(128'h0, 1),  {8'h03, 128'h0});
        chk("gold_k0_w5",  gold_word(128'h0, 5),  {8'h3E, 128'h0});
        chk("gold_k0_w39", gold_word(128'h0, 39), {8'h1A, 128'h0});
        chk("gold_k2_w0",  gold_word(128'h000102030405060708090A0B0C0D0E0F, 0),
            {8'h01, 128'h000102030405060708090A0B0C0D0E0F});
        chk("gold_k2_w1",  gold_word(128'h000102030405060708090A0B0C0D0E0F, 1),
            {8'h03, 128'h4303E0F0000102030405060708090A0B});

        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        do_run(128'h0, -1, -1);
        repeat (2) @(negedge clk);
        do_run(128'h000102030405060708090A0B0C0D0E0F, -1, -1);
        do_run(rand_key(), 10, -1);
        repeat (3) @(negedge clk);
        do_run(rand_key(), -1, 20);
        repeat (2) @(negedge clk);
        do_run(rand_key(), -1, -1);
        for (int r = 0; r < 3; r++) do_run(rand_key(), -1, -1);

        // Free-running random start pulses, including during WRITE and DONE.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            in_start = ($urandom_range(0, 7) == 0);
            in_key   = rand_key();
        end
        in_start = 1'b0;
        repeat (50) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
